// File: rtl/clk_ratio_mon_pkg.sv
// Purpose: shared FSM state encoding and parameter defaults for the clock-ratio monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_ratio_mon_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 1024;
  localparam int LOCK_N_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

endpackage

// File: rtl/clk_ratio_mon_sync.sv
// Purpose: bring the asynchronous monitored clock into clk and flag its rising edges.
// Latency: rise_o pulses 3 clk cycles after mon_clk_i rises.
// Backpressure: none; free-running, one pulse per detected rising edge.
module clk_ratio_mon_sync
  import clk_ratio_mon_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mon_clk_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  // Two-flop synchronizer, a delayed copy for edge compare, and a registered edge pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= mon_clk_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/clk_ratio_mon.sv
// Purpose: measure mon_clk period in clk cycles, track lock/error/stall; history via CLK_RATIO_MON_HIST_EN.
// Latency: period/period_vld update 4 clk cycles after the mon_clk rising edge that ends a period.
// Backpressure: none; every completed period is reported as a one-cycle period_vld pulse.
module clk_ratio_mon
  import clk_ratio_mon_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int LOCK_N  = LOCK_N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  input  logic             en,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [7:0]       tol,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             err,
  output logic             stalled,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
);

  // Lock counter saturates at LOCK_N, so it needs room for that value.
  localparam int LW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [LW-1:0]    LOCK_MAX = LW'(LOCK_N);
  localparam logic [LW-1:0]    LOCK_PRE = LW'(LOCK_N - 1);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT - 1);
  // Tolerance math is one bit wider than the period so the difference never wraps,
  // and at least 9 bits so the 8-bit tolerance always fits.
  localparam int DW = (CNT_W + 1 > 9) ? CNT_W + 1 : 9;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             stalled_q, stalled_d;

  logic             rise;
  logic [CNT_W-1:0] p_new;
  logic [DW-1:0]    p_ext, e_ext, t_ext, diff;
  logic             in_tol;

  clk_ratio_mon_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .mon_clk_i (mon_clk),
    .rise_o    (rise)
  );

  // Period candidate for the edge now arriving; a saturated counter reports all-ones.
  assign p_new  = (cnt_q == '1) ? '1 : cnt_q + CNT_W'(1);
  assign p_ext  = DW'(p_new);
  assign e_ext  = DW'(exp_period);
  assign t_ext  = DW'(tol);
  assign diff   = (p_ext >= e_ext) ? (p_ext - e_ext) : (e_ext - p_ext);
  assign in_tol = (diff <= t_ext);

  // State and measurement registers; reset discards any partial count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      vld_q      <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      stalled_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      vld_q      <= vld_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      stalled_q  <= stalled_d;
    end
  end

  // Next-state: arm on enable, measure between edges, fall back to ARM on timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    vld_d      = 1'b0;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    // Clear first so a same-cycle set below wins over err_clr.
    err_d      = err_q & ~err_clr;
    stalled_d  = stalled_q;

    if (!en) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
      stalled_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          // First edge only starts the count; there is no period to report yet.
          if (rise) begin
            state_d   = ST_MEASURE;
            cnt_d     = '0;
            stalled_d = 1'b0;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            cnt_d     = '0;
            stalled_d = 1'b0;
            period_d  = p_new;
            vld_d     = 1'b1;
            if (in_tol) begin
              if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + LW'(1);
              if (lock_cnt_q >= LOCK_PRE) locked_d = 1'b1;
            end else begin
              lock_cnt_d = '0;
              locked_d   = 1'b0;
              if (locked_q) err_d = 1'b1;
            end
          end else if (cnt_q == TO_VAL) begin
            // Counter is left at the timeout value so the stall point stays visible.
            stalled_d  = 1'b1;
            state_d    = ST_ARM;
            locked_d   = 1'b0;
            lock_cnt_d = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign stalled    = stalled_q;

`ifdef CLK_RATIO_MON_HIST_EN
  logic             hist_vld_q, hist_vld_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  // Extremes are folded in the cycle after each reported period; the first one loads both.
  always_comb begin
    hist_vld_d = hist_vld_q;
    min_d      = min_q;
    max_d      = max_q;
    if (vld_q) begin
      hist_vld_d = 1'b1;
      if (!hist_vld_q || period_q < min_q) min_d = period_q;
      if (!hist_vld_q || period_q > max_q) max_d = period_q;
    end
  end

  // History registers survive enable changes; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_vld_q <= 1'b0;
      min_q      <= '0;
      max_q      <= '0;
    end else begin
      hist_vld_q <= hist_vld_d;
      min_q      <= min_d;
      max_q      <= max_d;
    end
  end

  assign min_period = min_q;
  assign max_period = max_q;
`else
  assign min_period = '0;
  assign max_period = '0;
`endif

endmodule

// File: tb/tb_clk_ratio_mon.sv
// Purpose: self-checking bench for clk_ratio_mon with a period-list reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_ratio_mon;
  import clk_ratio_mon_pkg::*;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1024;
  localparam int LOCK_N  = 4;

  logic             clk;
  logic             rst;
  logic             mon_clk;
  logic             en;
  logic [CNT_W-1:0] exp_period;
  logic [7:0]       tol;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             err;
  logic             stalled;
  logic [CNT_W-1:0] min_period;
  logic [CNT_W-1:0] max_period;

  int n_tests = 0;
  int n_fail  = 0;

  int per_q[$];
  int obs_p[$];
  bit obs_l[$];
  bit obs_e[$];

  clk_ratio_mon #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .LOCK_N(LOCK_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .mon_clk    (mon_clk),
    .en         (en),
    .exp_period (exp_period),
    .tol        (tol),
    .err_clr    (err_clr),
    .period     (period),
    .period_vld (period_vld),
    .locked     (locked),
    .err        (err),
    .stalled    (stalled),
    .min_period (min_period),
    .max_period (max_period)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every reported period with the status seen alongside it.
  always @(negedge clk) begin
    if (period_vld) begin
      obs_p.push_back(int'(period));
      obs_l.push_back(locked);
      obs_e.push_back(err);
    end
  end

  task automatic clear_obs();
    obs_p.delete();
    obs_l.delete();
    obs_e.delete();
  endtask

  // One mon_clk period of p clk cycles, starting with a rising edge.
  task automatic drive_period(input int p);
    mon_clk = 1'b1;
    repeat (p / 2) @(negedge clk);
    mon_clk = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  // Drive per_q, then one closing edge so the last period is measured.
  task automatic drive_seq();
    foreach (per_q[i]) drive_period(per_q[i]);
    mon_clk = 1'b1;
    repeat (2) @(negedge clk);
    mon_clk = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Drop enable for one cycle (clears lock) and clear err, leaving the monitor armed.
  task automatic rearm();
    @(negedge clk);
    en      = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    en      = 1'b1;
    repeat (2) @(negedge clk);
    clear_obs();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mon_clk = 1'b0; err_clr = 1'b0;
    exp_period = '0; tol = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (period !== '0)    begin n_fail++; $display("FAIL reset_period: got %0d want 0", period); end
    n_tests++; if (period_vld !== 0) begin n_fail++; $display("FAIL reset_vld: got %0d want 0", period_vld); end
    n_tests++; if (locked !== 0)     begin n_fail++; $display("FAIL reset_locked: got %0d want 0", locked); end
    n_tests++; if (err !== 0)        begin n_fail++; $display("FAIL reset_err: got %0d want 0", err); end
    n_tests++; if (stalled !== 0)    begin n_fail++; $display("FAIL reset_stalled: got %0d want 0", stalled); end
    n_tests++; if (min_period !== '0 || max_period !== '0) begin
      n_fail++; $display("FAIL reset_hist: got %0d/%0d want 0/0", min_period, max_period);
    end
    rst = 1'b1;
  endtask

  task automatic test_div2();
    rearm();
    exp_period = 2; tol = 0;
    per_q = {2, 2, 2, 2, 2, 2};
    drive_seq();
    n_tests++; if (obs_p.size() != 6) begin n_fail++; $display("FAIL div2_count: got %0d want 6", obs_p.size()); end
    foreach (obs_p[i]) begin
      n_tests++; if (obs_p[i] != 2) begin n_fail++; $display("FAIL div2_period[%0d]: got %0d want 2", i, obs_p[i]); end
      n_tests++; if (obs_l[i] != (i >= LOCK_N - 1)) begin
        n_fail++; $display("FAIL div2_locked[%0d]: got %0d want %0d", i, obs_l[i], i >= LOCK_N - 1);
      end
    end
  endtask

  task automatic test_stall();
    int n0;
    n0 = obs_p.size();
    repeat (1100) @(negedge clk);
    n_tests++; if (stalled !== 1) begin n_fail++; $display("FAIL stall_set: got %0d want 1", stalled); end
    n_tests++; if (locked !== 0)  begin n_fail++; $display("FAIL stall_locked: got %0d want 0", locked); end
    n_tests++; if (dut.cnt_q !== 16'(TIMEOUT - 1)) begin
      n_fail++; $display("FAIL stall_cnt: got %0d want %0d", dut.cnt_q, TIMEOUT - 1);
    end
    n_tests++; if (dut.state_q !== ST_ARM) begin n_fail++; $display("FAIL stall_state: got %0d want %0d", dut.state_q, ST_ARM); end
    drive_period(4);
    repeat (6) @(negedge clk);
    n_tests++; if (stalled !== 0) begin n_fail++; $display("FAIL stall_clear: got %0d want 0", stalled); end
    n_tests++; if (dut.state_q !== ST_MEASURE) begin
      n_fail++; $display("FAIL stall_rearm_state: got %0d want %0d", dut.state_q, ST_MEASURE);
    end
    n_tests++; if (obs_p.size() != n0) begin n_fail++; $display("FAIL stall_no_period: got %0d want %0d", obs_p.size(), n0); end
  endtask

  task automatic test_err();
    rearm();
    exp_period = 8; tol = 1;
    per_q = {8, 8, 8, 8, 8, 11};
    drive_seq();
    n_tests++; if (obs_p.size() != 6) begin n_fail++; $display("FAIL err_count: got %0d want 6", obs_p.size()); end
    if (obs_p.size() == 6) begin
      n_tests++; if (obs_l[4] != 1)  begin n_fail++; $display("FAIL err_prelock: got %0d want 1", obs_l[4]); end
      n_tests++; if (obs_p[5] != 11) begin n_fail++; $display("FAIL err_period: got %0d want 11", obs_p[5]); end
      n_tests++; if (obs_e[5] != 1)  begin n_fail++; $display("FAIL err_set: got %0d want 1", obs_e[5]); end
      n_tests++; if (obs_l[5] != 0)  begin n_fail++; $display("FAIL err_unlock: got %0d want 0", obs_l[5]); end
    end
    n_tests++; if (err !== 1) begin n_fail++; $display("FAIL err_sticky: got %0d want 1", err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_tests++; if (err !== 0) begin n_fail++; $display("FAIL err_clr: got %0d want 0", err); end
  endtask

  task automatic test_en_drop();
    rearm();
    exp_period = 6; tol = 0;
    per_q = {6, 6, 6, 6, 6};
    drive_seq();
    n_tests++; if (locked !== 1) begin n_fail++; $display("FAIL endrop_prelock: got %0d want 1", locked); end
    en = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL endrop_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    n_tests++; if (locked !== 0)  begin n_fail++; $display("FAIL endrop_locked: got %0d want 0", locked); end
    n_tests++; if (period !== 6)  begin n_fail++; $display("FAIL endrop_period: got %0d want 6", period); end
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int ex, tl, run;
      bit lk, er;
      int exp_l[$];
      bit exp_lk[$];
      bit exp_er[$];
      rearm();
      ex = $urandom_range(8, 20);
      tl = $urandom_range(0, 3);
      exp_period = CNT_W'(ex);
      tol = 8'(tl);
      per_q.delete();
      for (int k = 0; k < 12; k++) begin
        int p;
        if ($urandom_range(0, 9) < 7) p = ex - tl + $urandom_range(0, 2 * tl);
        else if ($urandom_range(0, 1) == 1) p = ex + tl + 1 + $urandom_range(0, 3);
        else p = ex - tl - 1 - $urandom_range(0, 2);
        per_q.push_back(p);
      end
      // Reference: each period's lock/err outcome from the tolerance rule.
      run = 0; lk = 0; er = 0;
      foreach (per_q[k]) begin
        int d;
        d = (per_q[k] > ex) ? per_q[k] - ex : ex - per_q[k];
        if (d <= tl) begin
          run++;
          lk = (run >= LOCK_N);
        end else begin
          if (lk) er = 1;
          run = 0;
          lk = 0;
        end
        exp_l.push_back(per_q[k]);
        exp_lk.push_back(lk);
        exp_er.push_back(er);
      end
      drive_seq();
      n_tests++; if (obs_p.size() != exp_l.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", r, obs_p.size(), exp_l.size());
      end else begin
        foreach (exp_l[k]) begin
          n_tests++; if (obs_p[k] != exp_l[k]) begin
            n_fail++; $display("FAIL rand%0d_period[%0d]: got %0d want %0d", r, k, obs_p[k], exp_l[k]);
          end
          n_tests++; if (obs_l[k] != exp_lk[k]) begin
            n_fail++; $display("FAIL rand%0d_locked[%0d]: got %0d want %0d", r, k, obs_l[k], exp_lk[k]);
          end
          n_tests++; if (obs_e[k] != exp_er[k]) begin
            n_fail++; $display("FAIL rand%0d_err[%0d]: got %0d want %0d", r, k, obs_e[k], exp_er[k]);
          end
        end
      end
    end
  endtask

  task automatic test_hist();
    int want_min, want_max;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    exp_period = 6; tol = 3;
    repeat (2) @(negedge clk);
    clear_obs();
    per_q = {6, 4, 9};
    drive_seq();
`ifdef CLK_RATIO_MON_HIST_EN
    want_min = 4; want_max = 9;
`else
    want_min = 0; want_max = 0;
`endif
    n_tests++; if (obs_p.size() != 3) begin n_fail++; $display("FAIL hist_count: got %0d want 3", obs_p.size()); end
    n_tests++; if (int'(min_period) != want_min) begin n_fail++; $display("FAIL hist_min: got %0d want %0d", min_period, want_min); end
    n_tests++; if (int'(max_period) != want_max) begin n_fail++; $display("FAIL hist_max: got %0d want %0d", max_period, want_max); end
  endtask

  task automatic test_reset_mid();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_tests++; if (period !== '0 || period_vld !== 0 || locked !== 0 || err !== 0 || stalled !== 0) begin
      n_fail++; $display("FAIL rstmid_outputs: got p=%0d v=%0d l=%0d e=%0d s=%0d want all 0",
                         period, period_vld, locked, err, stalled);
    end
    n_tests++; if (min_period !== '0 || max_period !== '0) begin
      n_fail++; $display("FAIL rstmid_hist: got %0d/%0d want 0/0", min_period, max_period);
    end
    n_tests++; if (dut.cnt_q !== '0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", dut.cnt_q); end
    n_tests++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_obs();
    drive_period(5);
    repeat (8) @(negedge clk);
    n_tests++; if (obs_p.size() != 0) begin n_fail++; $display("FAIL rstmid_first_edge: got %0d periods want 0", obs_p.size()); end
    drive_period(5);
    repeat (8) @(negedge clk);
    n_tests++; if (obs_p.size() != 1) begin
      n_fail++; $display("FAIL rstmid_second_edge: got %0d periods want 1", obs_p.size());
    end else begin
      n_tests++; if (obs_p[0] != 13) begin n_fail++; $display("FAIL rstmid_period: got %0d want 13", obs_p[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_div2();
    test_stall();
    test_err();
    test_en_drop();
    test_random();
    test_hist();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_ratio_mon.md
CLK_RATIO_MON -- requirements
Module: clk_ratio_mon

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the period counter and period fields.
REQ-002 SHALL have parameter TIMEOUT, default 1024: clk cycles without a mon_clk rising edge before stall.
REQ-003 SHALL have parameter LOCK_N, default 4: consecutive in-tolerance periods required for lock.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port mon_clk, input, 1: monitored divided clock, asynchronous to clk, sampled as data.
REQ-007 SHALL have port en, input, 1: monitor enable.
REQ-008 SHALL have port exp_period, input, CNT_W: expected period in clk cycles.
REQ-009 SHALL have port tol, input, 8: allowed absolute deviation in clk cycles.
REQ-010 SHALL have port err_clr, input, 1: clears sticky err.
REQ-011 SHALL have port period, output, CNT_W: last measured period.
REQ-012 SHALL have port period_vld, output, 1: one-cycle pulse when period updates.
REQ-013 SHALL have ports locked, err and stalled, each output, 1: lock status, sticky error, stall status.
REQ-014 SHALL have ports min_period and max_period, each output, CNT_W: history extremes.

Function
REQ-015 SHALL pass mon_clk through a 2-flop synchronizer plus an edge register; a rising edge is detected 3 clk cycles after mon_clk rises.
REQ-016 SHALL implement FSM IDLE -> ARM (en=1) -> MEASURE (first detected edge) -> ARM (timeout); any state -> IDLE on the cycle after en=0.
REQ-017 In MEASURE, the counter SHALL clear on each detected edge and increment otherwise; on edge, period <= cnt+1 and period_vld=1 on the next cycle.
REQ-018 The counter SHALL saturate at all-ones; a saturated period is reported as all-ones.
REQ-019 A period is in tolerance when |period - exp_period| <= tol, computed at CNT_W+1 bits with no wrap.
REQ-020 locked SHALL assert after LOCK_N consecutive in-tolerance periods, and deassert on any out-of-tolerance period, stall or en=0.
REQ-021 err SHALL set on an out-of-tolerance period while locked=1; err_clr SHALL clear it; simultaneous set and clear SHALL leave err=1.
REQ-022 stalled SHALL set when cnt reaches TIMEOUT-1 with no edge, force ARM and clear locked, and clear on the next detected edge.
REQ-023 With en=0, period, min_period, max_period and err SHALL hold their values; the counter and lock count SHALL clear.

Reset
REQ-024 On rst=0, all outputs SHALL be 0, FSM SHALL be IDLE, and synchronizer flops, counter and lock count SHALL be 0.
REQ-025 Reset mid-measurement SHALL abort immediately and discard the partial count.

Configuration
REQ-026 With CLK_RATIO_MON_HIST_EN defined, min_period/max_period SHALL track extremes of all valid periods since reset; the first period SHALL load both.
REQ-027 Without CLK_RATIO_MON_HIST_EN, min_period and max_period SHALL be constant 0 and the comparison logic SHALL be absent.

Structure
REQ-028 Package clk_ratio_mon_pkg SHALL hold the FSM state enum and the CNT_W, TIMEOUT and LOCK_N defaults.
REQ-029 The synchronizer and edge detector SHALL be sub-module clk_ratio_mon_sync.

Verification
REQ-030 mon_clk driven by a toggle-every-clk divider, exp_period=2, tol=0 -> period=2 on every period_vld, locked=1 after the 4th period_vld.
REQ-031 Locked at exp_period=8, tol=1, then one period of 11 -> err=1, locked=0; then err_clr=1 -> err=0.
REQ-032 mon_clk held constant for 1100 cycles, TIMEOUT=1024 -> stalled=1 with cnt at 1023, FSM=ARM; next edge -> stalled=0.
REQ-033 en dropped mid-period -> FSM=IDLE next cycle, locked=0, period unchanged.
REQ-034 rst asserted mid-measure -> all outputs 0 asynchronously; after release and en=1, first period_vld comes after two edges.
REQ-035 HIST_EN with periods 6, 4, 9 -> min_period=4, max_period=9; without the macro -> both 0.
